fp_accumulator: RTL and testbench
=================================

# fp_accumulator

Streaming floating-point vector reducer built around the pipelined `fp_adder`. It sums an arbitrary-length stream of WIDTH-bit floats into one scalar per vector, using `in_last` as the delimiter. It sits directly downstream of the multiplier array in the dot-product path of the LCMV filter, and is the consumer and feedback source of `fp_adder`'s results. Up to LATENCY partial sums circulate through the adder; they are reduced to one value after the last beat.

## Interface
- `WIDTH`, 32: float word width; forwarded to `fp_adder`.
- `LATENCY`, 11: `fp_adder` latency in cycles; forwarded.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low. Drives `fp_adder.rst` as `~rst_n`.
- `in_data` in WIDTH: operand beat.
- `in_valid` in 1: the beat is present.
- `in_last` in 1: marks the final beat of a vector; qualified by `in_valid && in_ready`.
- `in_ready` out 1: the block accepts beats; high only in ACCUM.
- `out_data` out WIDTH: vector sum; holds its value until the next result.
- `out_valid` out 1: one-cycle pulse when `out_data` is new.
- `busy` out 1: high in DRAIN.

## Operation
- Beat acceptance: a beat is accepted when `in_valid && in_ready`.
- `live` counter: number of partial sums held or in flight. Width is `$clog2(LATENCY+2)`.
- `hold` register: one partial sum, with a `hold_v` flag.
- `res`: the adder result, qualified by the adder's valid output.
- ACCUM state, adder issue whenever a beat is accepted or `res` is valid:
  - `a` = accepted beat ? `in_data` : FP_ZERO.
  - `b` = `res` valid ? `res` : FP_ZERO.
  - Beat only: `live`+1.
  - Beat and `res`: `live` unchanged.
  - `res` only (recirculate x+0): `live` unchanged.
- Accepting a beat with `in_last` moves the block to DRAIN on the next cycle. Beats after that one are not accepted.
- DRAIN state, on each valid `res`:
  - `live`==1: capture `out_data`=`res`, pulse `out_valid`, go to ACCUM.
  - `hold_v`=0 and `live`>1: `hold`=`res`, `hold_v`=1.
  - `hold_v`=1: issue `hold`+`res`, clear `hold_v`, `live`-1.
- The case "`live`==1 and `hold_v`" cannot occur: a result is emitted only from `res`. No recirculation occurs in DRAIN.
- Arithmetic: no rounding control. The summation order is fully determined by input timing, so results are bit-reproducible for identical stimulus.
- A zero-length vector is impossible, because `in_last` always rides on a data beat.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `live`=0, `hold_v`=0. State is ACCUM.
  - `in_ready`=1 on the first cycle after `rst_n` deasserts.
  - `in_ready` and `busy` are registered from state.
- Single-beat vector accepted in cycle t: `out_valid` asserts in cycle t+LATENCY+1.
- Drain bound: `out_valid` asserts at most LATENCY*($clog2(LATENCY)+2) cycles after the last beat.
- `in_ready` falls in the cycle after the `in_last` beat. It rises in the cycle after the `out_valid` pulse. A beat offered during DRAIN is held by the source and not lost.
- Simultaneous beat and `res` in the same cycle: merged into one issue, with no stall and no loss.
- `in_valid` gaps: the pipeline keeps circulating, and no sum is dropped.
- Reset mid-operation: the state, `live`, `hold`, and the adder pipeline all clear. The in-flight vector produces no `out_valid`.

## Structure
- `fp_pkg` holds:
  - `FP_ZERO` (WIDTH'0).
  - The `acc_state_t` enum {ACCUM, DRAIN}.
- Single sub-module: the existing `fp_adder` #(WIDTH, LATENCY). Its `ready` input is driven by the issue strobe.
- No other hierarchy.

## Test plan
- Contiguous beats 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000) with last on the 4th -> exactly one `out_valid`, `out_data`=0x41200000.
- 32 contiguous beats of 1.0 -> `out_data`=0x42000000. `in_ready` is low from the cycle after last until the cycle after `out_valid`.
- Single beat 5.0 (0x40A00000) with last in cycle t -> `out_valid` at t+12, `out_data`=0x40A00000.
- 20 beats of 1.0 with random `in_valid` gaps of 0-5 cycles -> `out_data`=0x41A00000.
- Vector {1,2,3} then, back-to-back, {4,5,6} offered during DRAIN -> two pulses in order: 0x40C00000 then 0x41700000.
- `rst_n` low for 1 cycle mid-DRAIN -> no `out_valid` for that vector. Next vector {2.0, 2.0} -> 0x40800000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point reduction path.
package fp_pkg;

    localparam int FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] FP_ZERO = '0;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

endpackage

// File: rtl/fp_adder.sv
// Pipelined IEEE-754 adder: combinational sum followed by a LATENCY-deep
// delay line. Denormals flush to zero; results are truncated.
module fp_adder
    import fp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int EW   = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
    localparam int MW   = WIDTH - 1 - EW;
    localparam int XW   = MW + 5;
    localparam int EMAX = (1 << EW) - 1;

    logic [WIDTH-1:0] big;
    logic [WIDTH-1:0] sml;
    logic [WIDTH-1:0] sum;
    logic [XW-1:0]    mb;
    logic [XW-1:0]    ms;
    logic [XW-1:0]    mag;
    logic [XW-1:0]    norm;
    int               eb;
    int               es;
    int               e;
    int               lz;
    int unsigned      sh;

    always_comb begin
        big = a;
        sml = b;
        if (b[WIDTH-2:0] > a[WIDTH-2:0]) begin
            big = b;
            sml = a;
        end
        eb   = int'(big[WIDTH-2:MW]);
        es   = int'(sml[WIDTH-2:MW]);
        sh   = int'(eb - es);
        mb   = {2'b01, big[MW-1:0], 3'b000};
        ms   = {2'b01, sml[MW-1:0], 3'b000} >> sh;
        mag  = (big[WIDTH-1] == sml[WIDTH-1]) ? mb + ms : mb - ms;
        lz   = XW;
        for (int i = XW - 1; i >= 0; i--) begin
            if (mag[i] && lz == XW) lz = XW - 1 - i;
        end
        norm = '0;
        e    = 0;
        sum  = WIDTH'(FP_ZERO);
        if (eb == 0) begin
            sum = WIDTH'(FP_ZERO);
        end else if (es == 0 || eb == EMAX) begin
            sum = big;
        end else if (lz != XW) begin
            if (lz == 0) begin
                norm = mag >> 1;
                e    = eb + 1;
            end else begin
                norm = mag << (lz - 1);
                e    = eb - lz + 1;
            end
            if (e >= EMAX)
                sum = {big[WIDTH-1], {EW{1'b1}}, {MW{1'b0}}};
            else if (e > 0)
                sum = {big[WIDTH-1], e[EW-1:0], norm[XW-3:3]};
        end
    end

    logic [WIDTH-1:0]   pipe_d [LATENCY];
    logic [LATENCY-1:0] pipe_v;

    always_ff @(posedge clk) begin
        if (rst) pipe_v <= '0;
        else     pipe_v <= {pipe_v[LATENCY-2:0], ready};
    end

    always_ff @(posedge clk) begin
        pipe_d[0] <= sum;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
    end

    assign result = pipe_d[LATENCY-1];
    assign valid  = pipe_v[LATENCY-1];

endmodule

// File: rtl/fp_accumulator.sv
// Streaming vector reducer: partial sums circulate through fp_adder and
// are pairwise folded to one scalar once the last beat is in.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    localparam int LW = $clog2(LATENCY + 2);

    acc_state_t       state;
    acc_state_t       state_n;
    logic [LW-1:0]    live;
    logic [LW-1:0]    live_n;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_n;
    logic             hold_v;
    logic             hold_v_n;
    logic             issue;
    logic             cap;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] res;
    logic             res_v;
    logic             accept;

    assign accept = in_valid && in_ready;

    fp_adder #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_add (
        .clk    (clk),
        .rst    (~rst_n),
        .ready  (issue),
        .a      (add_a),
        .b      (add_b),
        .result (res),
        .valid  (res_v)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (accept && in_last) state_n = DRAIN;
            DRAIN: if (res_v && live == LW'(1)) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        cap      = 1'b0;
        add_a    = WIDTH'(FP_ZERO);
        add_b    = WIDTH'(FP_ZERO);
        live_n   = live;
        hold_n   = hold;
        hold_v_n = hold_v;
        unique case (state)
            ACCUM: begin
                issue = accept || res_v;
                if (accept) add_a = in_data;
                if (res_v)  add_b = res;
                if (accept && !res_v) live_n = live + LW'(1);
            end
            DRAIN: begin
                if (res_v) begin
                    if (live == LW'(1)) begin
                        cap    = 1'b1;
                        live_n = '0;
                    end else if (!hold_v) begin
                        hold_n   = res;
                        hold_v_n = 1'b1;
                    end else begin
                        issue    = 1'b1;
                        add_a    = hold;
                        add_b    = res;
                        hold_v_n = 1'b0;
                        live_n   = live - LW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // in_ready stays low for one ACCUM cycle after a result is emitted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live      <= '0;
            hold      <= '0;
            hold_v    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            live      <= live_n;
            hold      <= hold_n;
            hold_v    <= hold_v_n;
            out_valid <= cap;
            if (cap) out_data <= res;
            in_ready  <= (state == ACCUM) && (state_n == ACCUM);
            busy      <= (state_n == DRAIN);
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with hand-computed float sums.
module tb_fp_accumulator;

    localparam int W   = 32;
    localparam int LAT = 11;

    localparam logic [W-1:0] F1  = 32'h3F800000;
    localparam logic [W-1:0] F2  = 32'h40000000;
    localparam logic [W-1:0] F3  = 32'h40400000;
    localparam logic [W-1:0] F4  = 32'h40800000;
    localparam logic [W-1:0] F5  = 32'h40A00000;
    localparam logic [W-1:0] F6  = 32'h40C00000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    logic [W-1:0] rx_d [$];
    int           rx_c [$];

    fp_accumulator #(
        .WIDTH   (W),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            rx_d.push_back(out_data);
            rx_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("send_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (rx_d.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("out_count", 32'(rx_d.size()), 32'(n));
    endtask

    initial begin
        int base;
        int c_last;
        logic low_ok;
        int k;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // {1,2,3,4} -> 10.0, exactly one pulse
        send(F1, 1'b0);
        send(F2, 1'b0);
        send(F3, 1'b0);
        send(F4, 1'b1);
        gap(1);
        wait_out(1);
        check("sum4", rx_d[0], 32'h41200000);
        gap(30);
        check("sum4_one_pulse", 32'(rx_d.size()), 32'd1);

        // 32 x 1.0 -> 32.0 with in_ready profile
        base = rx_d.size();
        for (int i = 0; i < 32; i++) send(F1, i == 31);
        c_last = acc_cyc;
        gap(1);
        check("ir_fall", {31'd0, in_ready}, 32'd0);
        check("busy_drain", {31'd0, busy}, 32'd1);
        low_ok = 1'b1;
        k = 0;
        while (!out_valid && k < 300) begin
            if (in_ready) low_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check("ir_low_drain", {31'd0, low_ok}, 32'd1);
        check("ir_at_ov", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("ir_rise", {31'd0, in_ready}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        wait_out(base + 1);
        check("sum32", rx_d[base], 32'h42000000);
        check("drain_bound", 32'(rx_c[base] - c_last <= LAT * 6), 32'd1);
        gap(5);

        // single 5.0: latency LAT+1
        base = rx_d.size();
        send(F5, 1'b1);
        c_last = acc_cyc;
        gap(1);
        wait_out(base + 1);
        check("single_val", rx_d[base], F5);
        check("single_lat", 32'(rx_c[base] - c_last), 32'(LAT + 1));
        gap(5);

        // 20 x 1.0 with gaps -> 20.0
        base = rx_d.size();
        for (int i = 0; i < 20; i++) begin
            send(F1, i == 19);
            gap(int'($urandom_range(0, 5)));
        end
        gap(1);
        wait_out(base + 1);
        check("sum20_gaps", rx_d[base], 32'h41A00000);
        gap(5);

        // {1,2,3} then {4,5,6} held during DRAIN
        base = rx_d.size();
        send(F1, 1'b0);
        send(F2, 1'b0);
        send(F3, 1'b1);
        send(F4, 1'b0);
        send(F5, 1'b0);
        send(F6, 1'b1);
        gap(1);
        wait_out(base + 2);
        check("b2b_first", rx_d[base], 32'h40C00000);
        check("b2b_second", rx_d[base+1], 32'h41700000);
        gap(5);

        // reset mid-DRAIN drops the vector
        send(F1, 1'b0);
        send(F2, 1'b0);
        send(F3, 1'b1);
        gap(4);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        base = rx_d.size();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap(40);
        check("rst_no_out", 32'(rx_d.size()), 32'(base));
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        send(F2, 1'b0);
        send(F2, 1'b1);
        gap(1);
        wait_out(base + 1);
        check("after_rst_sum", rx_d[base], F4);

        gap(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
